datapath_sample_scheduler: RTL and testbench

//  Sequences one datapath_one_clock channel from a single CLK_24M domain.
//  - Generates the 1-of-DIV sampling strobe enable_sampling_3M.
//  - Holds the datapath in reset while idle.
//  - Discards WARMUP_SAMPLES settling outputs after start-up.
//  - Buffers channel_output into a small FIFO with a valid/ready handshake.
//  - Reports overruns when the downstream consumer stalls.

---
 rtl/dogx_sched_pkg.sv | 17 +
 rtl/sample_fifo.sv | 58 +++++
 rtl/datapath_sample_scheduler.sv | 106 ++++++++++
 tb/tb_datapath_sample_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dogx_sched_pkg.sv
// Shared types and sizing helpers for the datapath sample scheduler and its FIFO.
package dogx_sched_pkg;

   typedef enum logic [2:0] {IDLE, ARM, WARMUP, RUN, DRAIN} sched_state_t;

   localparam int DIV_DEF            = 8;
   localparam int WARMUP_SAMPLES_DEF = 16;
   localparam int CAPTURE_DELAY_DEF  = 2;
   localparam int N_BITS_OUT_DEF     = 9;
   localparam int FIFO_DEPTH_DEF     = 4;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO for captured samples; head holds its last value when empty.
module sample_fifo
   import dogx_sched_pkg::*;
#(
   parameter int WIDTH = N_BITS_OUT_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             CLK_24M,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             full
);

   localparam int PTR_W = cnt_width(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] hold_q;
   logic             do_push, do_pop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop && valid;
   // A pop frees the slot this cycle, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign data    = valid ? mem[rd_ptr] : hold_q;

   always_ff @(posedge CLK_24M) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/datapath_sample_scheduler.sv
// Sequences one datapath channel: sampling strobe, warm-up discard, output FIFO, overrun flag.
//   state  | meaning
//   IDLE   | datapath held in reset, no strobes, FIFO untouched
//   ARM    | datapath released, one cycle before the first strobe
//   WARMUP | strobes issued, captures discarded until the warm-up count is reached
//   RUN    | strobes issued, captures pushed to the FIFO
//   DRAIN  | no new strobes; in-flight captures land, FIFO empties, then IDLE
module datapath_sample_scheduler
   import dogx_sched_pkg::*;
#(
   parameter int DIV            = DIV_DEF,
   parameter int WARMUP_SAMPLES = WARMUP_SAMPLES_DEF,
   parameter int CAPTURE_DELAY  = CAPTURE_DELAY_DEF,
   parameter int N_BITS_OUT     = N_BITS_OUT_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
   input  logic                  CLK_24M,
   input  logic                  reset,
   input  logic                  run,
   output logic                  enable_sampling_3M,
   output logic                  datapath_reset,
   input  logic [N_BITS_OUT-1:0] channel_output,
   output logic [N_BITS_OUT-1:0] sample_data,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   input  logic                  clear_overrun,
   output logic                  overrun,
   output logic                  busy
);

   localparam int PHASE_W = cnt_width(DIV);
   localparam int WARM_W  = cnt_width(WARMUP_SAMPLES);

   sched_state_t             state_q, state_d;
   logic [PHASE_W-1:0]       phase_q;
   logic [WARM_W-1:0]        warm_q;
   logic [CAPTURE_DELAY-1:0] dly_q;
   logic                     sampling, tap, in_flight, push, pop, fifo_full;

   assign sampling           = (state_q == WARMUP) || (state_q == RUN);
   assign enable_sampling_3M = sampling && (phase_q == '0);
   assign datapath_reset     = (state_q != IDLE);
   assign busy               = (state_q != IDLE);
   assign tap                = dly_q[CAPTURE_DELAY-1];
   assign in_flight          = |dly_q;
   assign push               = tap && ((state_q == RUN) || (state_q == DRAIN));
   assign pop                = sample_valid && sample_ready && (state_q != IDLE);

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run) state_d = ARM;
         ARM:     state_d = WARMUP;
         WARMUP: begin
            if (!run) state_d = IDLE;
            else if (tap && (warm_q == WARM_W'(WARMUP_SAMPLES - 1))) state_d = RUN;
         end
         RUN:     if (!run) state_d = DRAIN;
         DRAIN:   if (!in_flight && !sample_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         phase_q <= '0;
         warm_q  <= '0;
         dly_q   <= '0;
         overrun <= 1'b0;
      end else begin
         if (!sampling)                          phase_q <= '0;
         else if (phase_q == PHASE_W'(DIV - 1))  phase_q <= '0;
         else                                    phase_q <= phase_q + 1'b1;

         if (state_q != WARMUP) warm_q <= '0;
         else if (tap)          warm_q <= warm_q + 1'b1;

         // Cleared in IDLE so a stale strobe from an aborted warm-up cannot land after restart.
         if (state_q == IDLE) dly_q <= '0;
         else                 dly_q <= (dly_q << 1) | CAPTURE_DELAY'(enable_sampling_3M);

         if (push && fifo_full && !pop) overrun <= 1'b1;
         else if (clear_overrun)        overrun <= 1'b0;
      end
   end

   sample_fifo #(
      .WIDTH (N_BITS_OUT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK_24M   (CLK_24M),
      .reset     (reset),
      .push      (push),
      .push_data (channel_output),
      .pop       (pop),
      .data      (sample_data),
      .valid     (sample_valid),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_datapath_sample_scheduler.sv
// Bench for datapath_sample_scheduler: directed timing checks plus a FIFO scoreboard on every pop.
module tb_datapath_sample_scheduler;

   localparam int DIV = 8, WARMUP = 16, CAP = 2, NB = 9, DEPTH = 4;

   logic          CLK_24M = 1'b0;
   logic          reset = 1'b0, run = 1'b0, sample_ready = 1'b0, clear_overrun = 1'b0;
   logic [NB-1:0] channel_output = '0;
   logic          enable_sampling_3M, datapath_reset, sample_valid, overrun, busy;
   logic [NB-1:0] sample_data;

   int n_vec = 0, n_miss = 0;
   int edge_no = 0, base = 0;
   int k = 0, model_cnt = 0, tap_cd = 0, tap_val = 0;
   int exp_q[$];

   datapath_sample_scheduler #(
      .DIV(DIV), .WARMUP_SAMPLES(WARMUP), .CAPTURE_DELAY(CAP),
      .N_BITS_OUT(NB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK_24M            (CLK_24M),
      .reset              (reset),
      .run                (run),
      .enable_sampling_3M (enable_sampling_3M),
      .datapath_reset     (datapath_reset),
      .channel_output     (channel_output),
      .sample_data        (sample_data),
      .sample_valid       (sample_valid),
      .sample_ready       (sample_ready),
      .clear_overrun      (clear_overrun),
      .overrun            (overrun),
      .busy               (busy)
   );

   always #5 CLK_24M = ~CLK_24M;
   always @(posedge CLK_24M) edge_no++;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Cycle n is the period between edge n-1 and edge n, edge 0 being the first edge with run=1.
   task automatic at_cycle(input int n);
      while (edge_no - base < n) @(negedge CLK_24M);
   endtask

   task automatic drive_cycle(input int n);
      while (edge_no - base < n) begin
         @(posedge CLK_24M);
         #1;
      end
   endtask

   task automatic start_run();
      @(posedge CLK_24M);
      #1;
      run  = 1'b1;
      k    = 0;
      base = edge_no;
   endtask

   // Reference model: strobe index drives channel_output; captures from index WARMUP on
   // enter a DEPTH-deep model FIFO, dropped when full without a pop.
   always @(negedge CLK_24M) begin : model
      logic pop_m;
      int   cnt_before;
      if (!reset) begin
         model_cnt = 0;
         tap_cd    = 0;
         k         = 0;
         exp_q.delete();
      end else begin
         cnt_before = model_cnt;
         pop_m      = (model_cnt > 0) && sample_ready;
         check_val("valid", sample_valid, model_cnt > 0);
         if (pop_m) begin
            check_val("pop_data", sample_data, exp_q.pop_front());
            model_cnt--;
         end
         if (tap_cd > 0) begin
            tap_cd--;
            if (tap_cd == 0 && tap_val >= WARMUP && !(cnt_before == DEPTH && !pop_m)) begin
               exp_q.push_back(tap_val);
               model_cnt++;
            end
         end
         if (enable_sampling_3M) begin
            channel_output = NB'(k);
            tap_val        = k;
            tap_cd         = CAP;
            k++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with run held high
      run = 1'b1;
      repeat (3) @(negedge CLK_24M);
      check_val("rst_strobe", enable_sampling_3M, 0);
      check_val("rst_dpr", datapath_reset, 0);
      check_val("rst_valid", sample_valid, 0);
      check_val("rst_overrun", overrun, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_data", sample_data, 0);
      #1 reset = 1'b1;
      base = edge_no;
      at_cycle(1);   check_val("c1_dpr", datapath_reset, 1);
                     check_val("c1_busy", busy, 1);
                     check_val("c1_strobe", enable_sampling_3M, 0);
      at_cycle(2);   check_val("c2_strobe", enable_sampling_3M, 1);
      at_cycle(3);   check_val("c3_strobe", enable_sampling_3M, 0);
      at_cycle(9);   check_val("c9_strobe", enable_sampling_3M, 0);
      at_cycle(10);  check_val("c10_strobe", enable_sampling_3M, 1);

      // Warm-up discard, first sample, overrun with consumer stalled
      at_cycle(132); check_val("c132_valid", sample_valid, 0);
      at_cycle(133); check_val("c133_valid", sample_valid, 1);
                     check_val("c133_data", sample_data, 16);
      at_cycle(164); check_val("c164_ovr", overrun, 0);
      at_cycle(165); check_val("c165_ovr", overrun, 1);
      at_cycle(173); check_val("c173_data", sample_data, 16);
                     check_val("c173_ovr", overrun, 1);
      drive_cycle(174); sample_ready = 1'b1; clear_overrun = 1'b1;
      drive_cycle(175); clear_overrun = 1'b0;
      at_cycle(175); check_val("c175_ovr", overrun, 0);

      // Full FIFO with push and pop in the same cycle
      drive_cycle(182); sample_ready = 1'b0;
      at_cycle(219); check_val("c219_valid", sample_valid, 1);
                     check_val("c219_data", sample_data, 23);
      drive_cycle(220); sample_ready = 1'b1;
      at_cycle(221); check_val("c221_ovr", overrun, 0);
                     check_val("c221_data", sample_data, 24);

      // run drops one cycle after a RUN strobe
      at_cycle(258); check_val("c258_strobe", enable_sampling_3M, 1);
      drive_cycle(259); run = 1'b0;
      at_cycle(261); check_val("c261_valid", sample_valid, 1);
                     check_val("c261_data", sample_data, 32);
      at_cycle(262); check_val("c262_busy", busy, 1);
      at_cycle(263); check_val("c263_busy", busy, 0);
                     check_val("c263_dpr", datapath_reset, 0);
      at_cycle(266); check_val("c266_strobe", enable_sampling_3M, 0);
      check_val("drain_empty", exp_q.size(), 0);

      // Abort during warm-up, then full restart
      start_run();
      at_cycle(1);   check_val("w_c1_dpr", datapath_reset, 1);
      at_cycle(2);   check_val("w_c2_strobe", enable_sampling_3M, 1);
      drive_cycle(20); run = 1'b0;
      at_cycle(21);  check_val("w_c21_busy", busy, 0);
                     check_val("w_c21_dpr", datapath_reset, 0);
                     check_val("w_c21_valid", sample_valid, 0);
      sample_ready = 1'b0;
      start_run();
      at_cycle(132); check_val("r_c132_valid", sample_valid, 0);
      at_cycle(133); check_val("r_c133_valid", sample_valid, 1);
                     check_val("r_c133_data", sample_data, 16);
      at_cycle(149); check_val("r_c149_valid", sample_valid, 1);

      // Reset with three samples queued during RUN
      drive_cycle(154);
      check_val("x_strobe_pre", enable_sampling_3M, 1);
      #1 reset = 1'b0;
      #1;
      check_val("x_strobe", enable_sampling_3M, 0);
      check_val("x_valid", sample_valid, 0);
      check_val("x_busy", busy, 0);
      check_val("x_dpr", datapath_reset, 0);
      repeat (2) @(negedge CLK_24M);
      sample_ready = 1'b1;
      #1 reset = 1'b1;
      base = edge_no;
      at_cycle(1);   check_val("y_c1_dpr", datapath_reset, 1);
      at_cycle(2);   check_val("y_c2_strobe", enable_sampling_3M, 1);
      at_cycle(10);  check_val("y_c10_strobe", enable_sampling_3M, 1);
      at_cycle(133); check_val("y_c133_valid", sample_valid, 1);
                     check_val("y_c133_data", sample_data, 16);
      drive_cycle(140); run = 1'b0;
      at_cycle(150); check_val("y_c150_busy", busy, 0);
      check_val("y_drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
